// File: rtl/bm_arb_pkg.sv
// Shared block-map constants and the read-arbiter FSM encoding.
// Imported by the arbiter, the bomberman movement logic and the enemy FSMs.
package bm_arb_pkg;

    localparam int BM_ADDR_W = 9;
    localparam int BM_DATA_W = 1;
    localparam int BM_N_REQ  = 4;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: rotate req so rr_ptr is bit 0, keep the lowest set bit, rotate back.
// Purely combinational; no backpressure.
module rr_priority_picker
    import bm_arb_pkg::*;
#(
    parameter int N_REQ = BM_N_REQ,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] rot_first;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        int r;
        r = (v >= N_REQ) ? v - N_REQ : v;
        return IDX_W'(r);
    endfunction

    always_comb begin
        rot     = '0;
        win_oh  = '0;
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[wrap_idx(i + int'(rr_ptr))];
        end
        rot_first = rot & (~rot + N_REQ'(1));
        for (int i = 0; i < N_REQ; i++) begin
            if (rot_first[i]) begin
                win_oh[wrap_idx(i + int'(rr_ptr))] = 1'b1;
                win_idx                            = wrap_idx(i + int'(rr_ptr));
            end
        end
    end

    assign win_any = |req;

endmodule

// File: rtl/block_map_rd_arbiter.sv
// Round-robin arbiter for the block-map read port (ARB_PLAYER_PRIORITY_EN: requester 0 always wins).
// Grant registered one cycle after req is seen; rd_valid pulses two cycles after; one access per 3 cycles.
module block_map_rd_arbiter
    import bm_arb_pkg::*;
#(
    parameter int N_REQ  = BM_N_REQ,
    parameter int ADDR_W = BM_ADDR_W,
    parameter int DATA_W = BM_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [ADDR_W-1:0]        bm_r_addr,
    input  logic [DATA_W-1:0]        bm_r_data
);

    localparam int               IDX_W    = idx_width(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_ptr_nxt;
    logic [IDX_W-1:0]  win_idx;
    logic [N_REQ-1:0]  pick_req;
    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [N_REQ-1:0]  arb_oh;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [DATA_W-1:0] rd_data_q;

`ifdef ARB_PLAYER_PRIORITY_EN
    assign pick_req = req & ~N_REQ'(1);
`else
    assign pick_req = req;
`endif

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (pick_req),
        .rr_ptr  (rr_ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_any (pick_any)
    );

    always_comb begin
        arb_oh     = pick_oh;
        arb_idx    = pick_idx;
        arb_any    = pick_any;
`ifdef ARB_PLAYER_PRIORITY_EN
        if (req[0]) begin
            arb_oh  = N_REQ'(1);
            arb_idx = '0;
            arb_any = 1'b1;
        end
        // Pointer cycles through 1..N_REQ-1 only; a player win leaves it alone.
        if (win_idx == '0) begin
            rr_ptr_nxt = rr_ptr;
        end else if (win_idx == LAST_IDX) begin
            rr_ptr_nxt = IDX_W'(1);
        end else begin
            rr_ptr_nxt = win_idx + IDX_W'(1);
        end
`else
        rr_ptr_nxt = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:  if (arb_any) state_d = ST_ADDR;
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: state_d = ST_ARB;
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= '0;
            rd_valid  <= '0;
            rd_data_q <= '0;
            bm_r_addr <= '0;
            rr_ptr    <= '0;
            win_idx   <= '0;
        end else begin
            rd_valid <= '0;
            case (state_q)
                ST_ARB: begin
                    if (arb_any) begin
                        gnt       <= arb_oh;
                        win_idx   <= arb_idx;
                        bm_r_addr <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                    end
                end
                ST_ADDR: rd_valid <= gnt;
                ST_DATA: begin
                    gnt       <= '0;
                    rd_data_q <= bm_r_data;
                    rr_ptr    <= rr_ptr_nxt;
                end
                default: gnt <= '0;
            endcase
        end
    end

    // RAM output register is already aligned to the DATA cycle; the local copy only holds it while idle.
    assign rd_data = (state_q == ST_DATA) ? bm_r_data : rd_data_q;

endmodule

// File: tb/tb_block_map_rd_arbiter.sv
// Bench for block_map_rd_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_block_map_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 1;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;
    logic [AW-1:0]   bm_r_addr;
    logic [DW-1:0]   bm_r_data;

    logic [DW-1:0]   mem [0:(1<<AW)-1];

    int              n_checks = 0;
    int              n_pass   = 0;
    int              m_ptr;
    logic [AW-1:0]   m_last_addr;
    logic [DW-1:0]   m_last_data;

    block_map_rd_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .bm_r_addr (bm_r_addr),
        .bm_r_data (bm_r_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bm_r_data <= mem[bm_r_addr];

    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        int c;
`ifdef ARB_PLAYER_PRIORITY_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
`ifdef ARB_PLAYER_PRIORITY_EN
            if (c != 0 && r[c]) return c;
`else
            if (r[c]) return c;
`endif
        end
        return -1;
    endfunction

    function automatic int model_next_ptr(input int w, input int ptr);
`ifdef ARB_PLAYER_PRIORITY_EN
        if (w == 0) return ptr;
        return (w == N - 1) ? 1 : w + 1;
`else
        return (w + 1) % N;
`endif
    endfunction

    task automatic commit(input int w, input logic [AW-1:0] a);
        m_ptr       = model_next_ptr(w, m_ptr);
        m_last_addr = a;
        m_last_data = mem[a];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        m_ptr       = 0;
        m_last_addr = '0;
        m_last_data = '0;
    endtask

    task automatic run_txn(input logic [N-1:0] r, output logic [N-1:0] g1, output logic [N-1:0] v1,
                           output logic [AW-1:0] a1, output logic [N-1:0] g2, output logic [N-1:0] v2,
                           output logic [DW-1:0] d2);
        @(negedge clk);
        req = r;
        @(negedge clk);
        g1 = gnt; v1 = rd_valid; a1 = bm_r_addr;
        @(negedge clk);
        g2 = gnt; v2 = rd_valid; d2 = rd_data;
        req = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (gnt !== '0) $display("FAIL reset_gnt: got %b want 0", gnt); else n_pass++;
        n_checks++; if (rd_valid !== '0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %b want 0", rd_data); else n_pass++;
        n_checks++; if (bm_r_addr !== '0) $display("FAIL reset_bm_r_addr: got %h want 0", bm_r_addr); else n_pass++;
    endtask

    task automatic test_single();
        logic [N-1:0] g1, v1, g2, v2; logic [AW-1:0] a1; logic [DW-1:0] d2;
        mem[9'h05A] = 1'b1;
        req_addr[1*AW +: AW] = 9'h05A;
        run_txn(4'b0010, g1, v1, a1, g2, v2, d2);
        n_checks++; if (g1 !== 4'b0010) $display("FAIL single_gnt_t1: got %b want 0010", g1); else n_pass++;
        n_checks++; if (v1 !== 4'b0000) $display("FAIL single_valid_t1: got %b want 0000", v1); else n_pass++;
        n_checks++; if (a1 !== 9'h05A) $display("FAIL single_addr: got %h want 05a", a1); else n_pass++;
        n_checks++; if (g2 !== 4'b0010) $display("FAIL single_gnt_t2: got %b want 0010", g2); else n_pass++;
        n_checks++; if (v2 !== 4'b0010) $display("FAIL single_valid_t2: got %b want 0010", v2); else n_pass++;
        n_checks++; if (d2 !== 1'b1) $display("FAIL single_data: got %b want 1", d2); else n_pass++;
        commit(1, 9'h05A);
        @(negedge clk);
        n_checks++; if (gnt !== '0 || rd_valid !== '0) $display("FAIL single_release: got gnt %b valid %b want 0", gnt, rd_valid); else n_pass++;
    endtask

    task automatic test_idle();
        req = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt !== '0 || rd_valid !== '0) $display("FAIL idle_out c=%0d: got gnt %b valid %b want 0", i, gnt, rd_valid);
            else n_pass++;
            n_checks++;
            if (bm_r_addr !== m_last_addr || rd_data !== m_last_data)
                $display("FAIL idle_hold c=%0d: got addr %h data %b want %h %b", i, bm_r_addr, rd_data, m_last_addr, m_last_data);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        int t, w; logic got;
        do_reset();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
        @(negedge clk);
        req = '1;
        t = 0;
        for (int k = 0; k < 5; k++) begin
            w = model_pick(req, m_ptr);
            got = 1'b0;
            for (int b = 0; b < 5 && !got; b++) begin
                @(negedge clk);
                t++;
                if (rd_valid !== '0) got = 1'b1;
            end
            n_checks++; if (!got) $display("FAIL rr_timeout k=%0d: got no rd_valid want %b", k, N'(1) << w); else n_pass++;
            n_checks++; if (t != 2 + 3*k) $display("FAIL rr_timing k=%0d: got cycle %0d want %0d", k, t, 2 + 3*k); else n_pass++;
            n_checks++; if (rd_valid !== N'(1) << w) $display("FAIL rr_order k=%0d: got %b want %b", k, rd_valid, N'(1) << w); else n_pass++;
            n_checks++;
            if (rd_data !== mem[req_addr[w*AW +: AW]]) $display("FAIL rr_data k=%0d: got %b want %b", k, rd_data, mem[req_addr[w*AW +: AW]]);
            else n_pass++;
            commit(w, req_addr[w*AW +: AW]);
        end
        req = '0;
    endtask

    task automatic test_addr_change();
        mem[9'h010] = 1'b1;
        mem[9'h011] = 1'b0;
        req_addr[2*AW +: AW] = 9'h010;
        @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        n_checks++; if (bm_r_addr !== 9'h010) $display("FAIL achg_addr: got %h want 010", bm_r_addr); else n_pass++;
        req_addr[2*AW +: AW] = 9'h011;
        @(negedge clk);
        n_checks++; if (rd_valid !== 4'b0100) $display("FAIL achg_valid: got %b want 0100", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== 1'b1) $display("FAIL achg_data: got %b want 1", rd_data); else n_pass++;
        n_checks++; if (bm_r_addr !== 9'h010) $display("FAIL achg_addr_hold: got %h want 010", bm_r_addr); else n_pass++;
        req = '0;
        commit(2, 9'h010);
    endtask

    task automatic test_priority();
        logic [N-1:0] g1, v1, g2, v2; logic [AW-1:0] a1; logic [DW-1:0] d2; int w;
        req_addr[0*AW +: AW] = AW'($urandom);
        req_addr[3*AW +: AW] = AW'($urandom);
        for (int k = 0; k < 6; k++) begin
            w = model_pick(4'b1001, m_ptr);
            run_txn(4'b1001, g1, v1, a1, g2, v2, d2);
            n_checks++; if (g1 !== N'(1) << w) $display("FAIL prio_gnt k=%0d: got %b want %b", k, g1, N'(1) << w); else n_pass++;
            n_checks++;
            if (v2 !== N'(1) << w || d2 !== mem[req_addr[w*AW +: AW]])
                $display("FAIL prio_valid k=%0d: got %b/%b want %b/%b", k, v2, d2, N'(1) << w, mem[req_addr[w*AW +: AW]]);
            else n_pass++;
            commit(w, req_addr[w*AW +: AW]);
        end
    endtask

    task automatic test_reset_midop();
        logic [N-1:0] g1, v1, g2, v2; logic [AW-1:0] a1; logic [DW-1:0] d2; logic [N-1:0] seen;
        req_addr[2*AW +: AW] = 9'h123;
        run_txn(4'b0100, g1, v1, a1, g2, v2, d2);
        commit(2, 9'h123);
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0010) $display("FAIL rmid_gnt_before: got %b want 0010", gnt); else n_pass++;
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        n_checks++; if (gnt !== '0 || rd_valid !== '0) $display("FAIL rmid_abort: got gnt %b valid %b want 0", gnt, rd_valid); else n_pass++;
        n_checks++; if (bm_r_addr !== '0) $display("FAIL rmid_addr: got %h want 0", bm_r_addr); else n_pass++;
        reset = 1'b0;
        m_ptr = 0; m_last_addr = '0; m_last_data = '0;
        seen = '0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | rd_valid;
        end
        n_checks++; if (seen !== '0) $display("FAIL rmid_no_valid: got %b want 0", seen); else n_pass++;
        req_addr[1*AW +: AW] = 9'h0C3;
        req_addr[3*AW +: AW] = 9'h13C;
        run_txn(4'b1010, g1, v1, a1, g2, v2, d2);
        n_checks++; if (v2 !== 4'b0010) $display("FAIL rmid_ptr_cleared: got %b want 0010", v2); else n_pass++;
        commit(1, 9'h0C3);
        req_addr[2*AW +: AW] = 9'h077;
        run_txn(4'b0100, g1, v1, a1, g2, v2, d2);
        n_checks++;
        if (g1 !== 4'b0100 || a1 !== 9'h077 || v2 !== 4'b0100 || d2 !== mem[9'h077])
            $display("FAIL rmid_after: got %b %h %b %b want 0100 077 0100 %b", g1, a1, v2, d2, mem[9'h077]);
        else n_pass++;
        commit(2, 9'h077);
    endtask

    task automatic test_random();
        int ps, w, next_free; logic pend; logic [AW-1:0] pa, ea; logic [DW-1:0] pd, ed; logic [N-1:0] eg, ev;
        pend = 1'b0; next_free = 0; ps = 0; w = 0; pa = '0; pd = '0;
        req = '0;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            eg = '0; ev = '0; ea = m_last_addr; ed = m_last_data;
            if (pend && c == ps + 1) begin
                eg = N'(1) << w; ea = pa;
            end else if (pend && c == ps + 2) begin
                eg = N'(1) << w; ev = eg; ea = pa; ed = pd;
            end
            n_checks++; if (gnt !== eg) $display("FAIL rand_gnt c=%0d: got %b want %b", c, gnt, eg); else n_pass++;
            n_checks++; if (rd_valid !== ev) $display("FAIL rand_valid c=%0d: got %b want %b", c, rd_valid, ev); else n_pass++;
            n_checks++; if (bm_r_addr !== ea) $display("FAIL rand_addr c=%0d: got %h want %h", c, bm_r_addr, ea); else n_pass++;
            n_checks++; if (rd_data !== ed) $display("FAIL rand_data c=%0d: got %b want %b", c, rd_data, ed); else n_pass++;
            if (pend && c == ps + 2) begin
                pend = 1'b0; m_last_addr = pa; m_last_data = pd;
            end
            for (int i = 0; i < N; i++) begin
                if (rd_valid[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    if (c < 380 && $urandom_range(2) == 0) begin
                        req[i] = 1'b1;
                        req_addr[i*AW +: AW] = AW'($urandom);
                    end
                end else if ($urandom_range(7) == 0) begin
                    req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            if (c >= next_free) begin
                if (req != '0) begin
                    w = model_pick(req, m_ptr);
                    ps = c; pa = req_addr[w*AW +: AW]; pd = mem[pa];
                    pend = 1'b1; next_free = c + 3;
                    m_ptr = model_next_ptr(w, m_ptr);
                end else begin
                    next_free = c + 1;
                end
            end
        end
        req = '0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; req = '0; req_addr = '0;
        m_ptr = 0; m_last_addr = '0; m_last_data = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        test_reset();
        test_single();
        test_idle();
        test_round_robin();
        test_addr_change();
        test_priority();
        test_reset_midop();
        test_random();
        test_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
